// File: rtl/multi_item_vending.sv
// Multi-item vending controller: nickel/dime/quarter credit, per-item price and stock,
// cancel/refund, and greedy serial change. Every output is registered.
module multi_item_vending #(
  parameter int unsigned                     CREDIT_W   = 8,
  parameter int unsigned                     MAX_CREDIT = 100,
  parameter int unsigned                     N_ITEMS    = 4,
  parameter int unsigned                     SEL_W      = 2,
  parameter logic [N_ITEMS*CREDIT_W-1:0]     PRICE_LIST = {8'd50, 8'd35, 8'd25, 8'd15},
  parameter int unsigned                     STOCK_W    = 4,
  parameter int unsigned                     STOCK_INIT = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic [SEL_W-1:0]    sel,
  input  logic                vend_req,
  input  logic                cancel,
  input  logic                restock,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend_fail,
  output logic                dispense_out,
  output logic [SEL_W-1:0]    item_out,
  output logic                change_nickel,
  output logic                change_dime,
  output logic                change_quarter,
  output logic                done,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_ITEMS-1:0]  sold_out
);

  localparam logic [CREDIT_W-1:0] MaxCredit = CREDIT_W'(MAX_CREDIT);
  localparam logic [STOCK_W-1:0]  StockInit = STOCK_W'(STOCK_INIT);
  localparam logic [CREDIT_W-1:0] Val5      = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] Val10     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] Val25     = CREDIT_W'(25);

  typedef enum logic [1:0] {StIdle, StDispense, StChange, StDone} state_e;

  // Largest coin not exceeding the remaining credit.
  function automatic logic [CREDIT_W-1:0] change_coin(input logic [CREDIT_W-1:0] c);
    if (c >= Val25)      return Val25;
    else if (c >= Val10) return Val10;
    else                 return Val5;
  endfunction

  state_e                          r_state, w_state_d;
  logic [CREDIT_W-1:0]             r_credit, w_credit_d;
  logic [N_ITEMS-1:0][STOCK_W-1:0] r_stock, w_stock_d;
  logic [SEL_W-1:0]                r_item, w_item_d;

  logic                r_coin_accept, r_coin_reject, r_vend_fail, r_dispense;
  logic [SEL_W-1:0]    r_item_out;
  logic                r_chg_nickel, r_chg_dime, r_chg_quarter, r_done, r_busy;
  logic [N_ITEMS-1:0]  r_sold_out;

  logic                w_accept, w_reject, w_fail;
  logic                w_coin_any, w_coin_fits;
  logic [1:0]          w_coin_cnt;
  logic [CREDIT_W-1:0] w_coin_val, w_price, w_chg_now, w_chg_next;
  logic [CREDIT_W:0]   w_coin_sum;
  logic [STOCK_W-1:0]  w_stock_sel;
  logic                w_can_vend;

  logic                w_dispense_d, w_chg_nickel_d, w_chg_dime_d, w_chg_quarter_d;
  logic                w_done_d, w_busy_d;
  logic [SEL_W-1:0]    w_item_out_d;
  logic [N_ITEMS-1:0]  w_sold_out_d;

  assign w_coin_any  = nickel | dime | quarter;
  assign w_coin_cnt  = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
  assign w_coin_val  = quarter ? Val25 : (dime ? Val10 : (nickel ? Val5 : '0));
  assign w_coin_sum  = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_fits = (w_coin_cnt == 2'd1) && (w_coin_sum <= {1'b0, MaxCredit});
  assign w_price     = PRICE_LIST[int'(sel)*CREDIT_W +: CREDIT_W];
  assign w_stock_sel = r_stock[sel];
  assign w_can_vend  = (w_stock_sel != '0) && (r_credit >= w_price);
  assign w_chg_now   = change_coin(r_credit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_credit <= '0;
      r_stock  <= {N_ITEMS{StockInit}};
      r_item   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_credit <= w_credit_d;
      r_stock  <= w_stock_d;
      r_item   <= w_item_d;
    end
  end

  // Idle priority: cancel > vend_req > restock > coin. Coins are refused outside idle.
  always_comb begin
    w_state_d  = r_state;
    w_credit_d = r_credit;
    w_stock_d  = r_stock;
    w_item_d   = r_item;
    w_accept   = 1'b0;
    w_reject   = w_coin_any;
    w_fail     = 1'b0;
    case (r_state)
      StIdle: begin
        if (cancel) begin
          w_state_d = (r_credit != '0) ? StChange : StDone;
        end else if (vend_req && w_can_vend) begin
          w_credit_d     = r_credit - w_price;
          w_stock_d[sel] = w_stock_sel - STOCK_W'(1);
          w_item_d       = sel;
          w_state_d      = StDispense;
        end else begin
          if (vend_req) begin
            w_fail = 1'b1;
          end else if (restock) begin
            w_stock_d[sel] = StockInit;
          end
          if (w_coin_fits) begin
            w_accept   = 1'b1;
            w_reject   = 1'b0;
            w_credit_d = w_coin_sum[CREDIT_W-1:0];
          end
        end
      end
      StDispense: w_state_d = (r_credit != '0) ? StChange : StDone;
      StChange: begin
        w_credit_d = r_credit - w_chg_now;
        if (w_credit_d == '0) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  assign w_chg_next = change_coin(w_credit_d);

  always_comb begin
    w_dispense_d    = (w_state_d == StDispense);
    w_item_out_d    = w_dispense_d ? w_item_d : '0;
    w_chg_nickel_d  = (w_state_d == StChange) && (w_chg_next == Val5);
    w_chg_dime_d    = (w_state_d == StChange) && (w_chg_next == Val10);
    w_chg_quarter_d = (w_state_d == StChange) && (w_chg_next == Val25);
    w_done_d        = (w_state_d == StDone);
    w_busy_d        = (w_state_d != StIdle);
    for (int i = 0; i < N_ITEMS; i++) begin
      w_sold_out_d[i] = (w_stock_d[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coin_accept <= 1'b0;
      r_coin_reject <= 1'b0;
      r_vend_fail   <= 1'b0;
      r_dispense    <= 1'b0;
      r_item_out    <= '0;
      r_chg_nickel  <= 1'b0;
      r_chg_dime    <= 1'b0;
      r_chg_quarter <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_sold_out    <= (StockInit == '0) ? '1 : '0;
    end else begin
      r_coin_accept <= w_accept;
      r_coin_reject <= w_reject;
      r_vend_fail   <= w_fail;
      r_dispense    <= w_dispense_d;
      r_item_out    <= w_item_out_d;
      r_chg_nickel  <= w_chg_nickel_d;
      r_chg_dime    <= w_chg_dime_d;
      r_chg_quarter <= w_chg_quarter_d;
      r_done        <= w_done_d;
      r_busy        <= w_busy_d;
      r_sold_out    <= w_sold_out_d;
    end
  end

  assign coin_accept    = r_coin_accept;
  assign coin_reject    = r_coin_reject;
  assign vend_fail      = r_vend_fail;
  assign dispense_out   = r_dispense;
  assign item_out       = r_item_out;
  assign change_nickel  = r_chg_nickel;
  assign change_dime    = r_chg_dime;
  assign change_quarter = r_chg_quarter;
  assign done           = r_done;
  assign busy           = r_busy;
  assign credit         = r_credit;
  assign sold_out       = r_sold_out;

endmodule

// File: tb/tb_multi_item_vending.sv
// Scoreboard bench for multi_item_vending: a transaction-level model queues the expected
// output cycles, and a negedge monitor pops and compares whenever the DUT pulses.
module tb_multi_item_vending;

  localparam int CW    = 8;
  localparam int NI    = 4;
  localparam int SW    = 2;
  localparam int STW   = 4;
  localparam int SINIT = 3;
  localparam int MAXC  = 100;
  localparam logic [NI*CW-1:0] PRICES = {8'd50, 8'd35, 8'd25, 8'd15};

  int price_tab [NI] = '{15, 25, 35, 50};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
  logic [SW-1:0] sel = '0;
  logic          vend_req = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic          coin_accept, coin_reject, vend_fail, dispense_out;
  logic [SW-1:0] item_out;
  logic          change_nickel, change_dime, change_quarter, done, busy;
  logic [CW-1:0] credit;
  logic [NI-1:0] sold_out;

  multi_item_vending #(
    .CREDIT_W  (CW),
    .MAX_CREDIT(MAXC),
    .N_ITEMS   (NI),
    .SEL_W     (SW),
    .PRICE_LIST(PRICES),
    .STOCK_W   (STW),
    .STOCK_INIT(SINIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .nickel        (nickel),
    .dime          (dime),
    .quarter       (quarter),
    .sel           (sel),
    .vend_req      (vend_req),
    .cancel        (cancel),
    .restock       (restock),
    .coin_accept   (coin_accept),
    .coin_reject   (coin_reject),
    .vend_fail     (vend_fail),
    .dispense_out  (dispense_out),
    .item_out      (item_out),
    .change_nickel (change_nickel),
    .change_dime   (change_dime),
    .change_quarter(change_quarter),
    .done          (done),
    .busy          (busy),
    .credit        (credit),
    .sold_out      (sold_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          e_busy;
    logic          e_acc;
    logic          e_rej;
    logic          e_fail;
    logic          e_disp;
    logic [SW-1:0] e_item;
    logic          e_cn;
    logic          e_cd;
    logic          e_cq;
    logic          e_done;
    logic [CW-1:0] e_credit;
  } ev_t;

  ev_t exp_q [$];
  ev_t ops [$];
  int  total = 0;
  int  bad = 0;
  int  m_credit = 0;
  int  m_stock [NI];

  function automatic ev_t mk(input bit bz, input bit acc, input bit rej, input bit fl,
                             input bit dp, input int it, input int chg, input bit dn,
                             input int cr);
    ev_t e;
    e          = '0;
    e.e_busy   = bz;
    e.e_acc    = acc;
    e.e_rej    = rej;
    e.e_fail   = fl;
    e.e_disp   = dp;
    e.e_item   = SW'(it);
    e.e_cn     = (chg == 5);
    e.e_cd     = (chg == 10);
    e.e_cq     = (chg == 25);
    e.e_done   = dn;
    e.e_credit = CW'(cr);
    return e;
  endfunction

  function automatic int greedy(input int c);
    if (c >= 25) return 25;
    if (c >= 10) return 10;
    return 5;
  endfunction

  // Refund the whole model credit one coin per cycle, then a done cycle.
  function automatic void payout(input bit first_rej);
    int c;
    bit first;
    c     = m_credit;
    first = 1'b1;
    while (c > 0) begin
      ops.push_back(mk(1, 0, first & first_rej, 0, 0, 0, greedy(c), 0, c));
      c     = c - greedy(c);
      first = 1'b0;
    end
    ops.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    m_credit = 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_sold();
    int v;
    v = 0;
    for (int i = 0; i < NI; i++) if (m_stock[i] == 0) v |= (1 << i);
    return v;
  endfunction

  // One idle-cycle request. coins: bit0 nickel, bit1 dime, bit2 quarter.
  task automatic do_op(input bit can, input bit vnd, input bit rst, input int s,
                       input int coins, input bit inject);
    int  ncoin, val;
    bit  acc, rej;
    ev_t e;
    ops.delete();
    ncoin = ((coins & 1) != 0) + ((coins & 2) != 0) + ((coins & 4) != 0);
    val   = ((coins & 4) != 0) ? 25 : ((coins & 2) != 0) ? 10 : 5;
    acc   = (ncoin == 1) && (m_credit + val <= MAXC);
    rej   = (ncoin > 0) && !acc;
    if (can) begin
      if (m_credit > 0) payout(ncoin > 0);
      else ops.push_back(mk(1, 0, ncoin > 0, 0, 0, 0, 0, 1, 0));
    end else if (vnd && m_stock[s] > 0 && m_credit >= price_tab[s]) begin
      m_credit   = m_credit - price_tab[s];
      m_stock[s] = m_stock[s] - 1;
      ops.push_back(mk(1, 0, ncoin > 0, 0, 1, s, 0, 0, m_credit));
      if (m_credit > 0) payout(1'b0);
      else ops.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    end else begin
      if (!vnd && rst) m_stock[s] = SINIT;
      if (acc) m_credit = m_credit + val;
      if (vnd || ncoin > 0) ops.push_back(mk(0, acc, rej, vnd, 0, 0, 0, 0, m_credit));
    end
    // Requests and a coin thrown in while busy must be ignored / refused.
    inject = inject && (ops.size() >= 2);
    if (inject) begin
      e       = ops[1];
      e.e_rej = 1'b1;
      ops[1]  = e;
    end
    @(posedge clk); #1;
    nickel   = (coins & 1) != 0;
    dime     = (coins & 2) != 0;
    quarter  = (coins & 4) != 0;
    sel      = SW'(s);
    cancel   = can;
    vend_req = vnd;
    restock  = rst;
    foreach (ops[i]) exp_q.push_back(ops[i]);
    @(posedge clk); #1;
    {nickel, dime, quarter, cancel, vend_req, restock} = '0;
    if (inject) begin
      {nickel, cancel, vend_req, restock} = 4'b1111;
      sel = SW'($urandom_range(0, NI - 1));
      @(posedge clk); #1;
      {nickel, cancel, vend_req, restock} = '0;
    end
    repeat (ops.size() + 2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_events got=0 expected=%0d", exp_q.size());
      exp_q.delete();
    end
    chk("credit", int'(credit), m_credit);
    chk("sold_out", int'(sold_out), exp_sold());
    chk("busy_idle", int'(busy), 0);
  endtask

  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (reset_n) begin
      act          = '0;
      act.e_busy   = busy;
      act.e_acc    = coin_accept;
      act.e_rej    = coin_reject;
      act.e_fail   = vend_fail;
      act.e_disp   = dispense_out;
      act.e_item   = item_out;
      act.e_cn     = change_nickel;
      act.e_cd     = change_dime;
      act.e_cq     = change_quarter;
      act.e_done   = done;
      act.e_credit = credit;
      if (act.e_acc | act.e_rej | act.e_fail | act.e_disp | act.e_cn | act.e_cd | act.e_cq |
          act.e_done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got=%h expected=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            bad++;
            $display("FAIL event got=%h expected=%h", act, e);
          end
        end
      end
    end
  end

  initial begin
    int r, s, cs;
    for (int i = 0; i < NI; i++) m_stock[i] = SINIT;
    #12;
    chk("reset_pulses", int'({coin_accept, coin_reject, vend_fail, dispense_out, change_nickel,
                              change_dime, change_quarter, done, busy}), 0);
    chk("reset_item", int'(item_out), 0);
    chk("reset_credit", int'(credit), 0);
    chk("reset_sold_out", int'(sold_out), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // T1: 20c, buy item 0 (15c) -> one nickel back
    do_op(0, 0, 0, 0, 1, 0); do_op(0, 0, 0, 0, 1, 0); do_op(0, 0, 0, 0, 2, 0);
    do_op(0, 1, 0, 0, 0, 0);
    // T2: 50c, buy item 0 -> quarter then dime
    do_op(0, 0, 0, 0, 4, 0); do_op(0, 0, 0, 0, 4, 0);
    do_op(0, 1, 0, 0, 0, 1);
    // T3: 10c, item 3 too expensive, then cancel
    do_op(0, 0, 0, 0, 2, 0); do_op(0, 1, 0, 3, 0, 0); do_op(1, 0, 0, 0, 0, 0);
    // T4: credit ceiling and multi-coin reject
    for (int i = 0; i < 4; i++) do_op(0, 0, 0, 0, 4, 0);
    do_op(0, 0, 0, 0, 1, 0); do_op(0, 0, 0, 0, 3, 0);
    do_op(0, 1, 0, 1, 1, 0); do_op(1, 0, 0, 0, 2, 0);
    // T5: drain item 2, fail on empty stock, restock it
    for (int k = 0; k < SINIT + 1; k++) begin
      do_op(0, 0, 0, 0, 4, 0); do_op(0, 0, 0, 0, 2, 0); do_op(0, 1, 0, 2, 0, 0);
    end
    do_op(0, 0, 1, 2, 1, 0); do_op(1, 0, 0, 0, 0, 0);
    do_op(1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 99);
      s  = $urandom_range(0, NI - 1);
      cs = $urandom_range(0, 5);
      cs = (cs == 0) ? 0 : (cs == 1) ? 1 : (cs == 2 || cs == 5) ? 2 : (cs == 3) ? 4 : 5;
      if (r < 55)      do_op(0, 0, 0, s, cs, 0);
      else if (r < 78) do_op(0, 1, ($urandom_range(0, 1) == 1), s, cs, ($urandom_range(0, 2) == 0));
      else if (r < 88) do_op(1, ($urandom_range(0, 1) == 1), 0, s, cs, ($urandom_range(0, 2) == 0));
      else             do_op(0, 0, 1, s, cs, 0);
    end

    // T6: asynchronous reset in the middle of a refund
    do_op(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_op(0, 0, 0, 0, 4, 0);
    do_op(0, 1, 0, 1, 0, 0);
    @(posedge clk); #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_pulses", int'({coin_accept, coin_reject, vend_fail, dispense_out, change_nickel,
                           change_dime, change_quarter, done, busy}), 0);
    chk("t6_credit", int'(credit), 0);
    chk("t6_sold_out", int'(sold_out), 0);
    m_credit = 0;
    for (int i = 0; i < NI; i++) m_stock[i] = SINIT;
    @(negedge clk);
    reset_n = 1'b1;
    do_op(0, 0, 0, 0, 4, 0); do_op(0, 1, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
